network_source: RTL

//  Dispatch-side input stage; sits upstream of the network, mirroring network_sink downstream.

---
 rtl/network_source.sv | 127 ++++++++++++
 1 files changed

// File: rtl/network_source.sv
// network_source: dispatch-side input stage.
// Collects a per-run word stream (count C followed by C input indices) from
// the host, ORs the indices into a one-hot fire vector, and hands that vector
// to the network with a valid/ready handshake, one vector per run.
module network_source #(
  parameter int NET_NUM_INP = 8,
  parameter int SRC_WIDTH   = $clog2(NET_NUM_INP + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   src_valid,
  output logic                   src_ready,
  input  logic [SRC_WIDTH-1:0]   src,
  output logic                   net_valid,
  input  logic                   net_ready,
  output logic [NET_NUM_INP-1:0] net_inp,
  output logic                   err
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COLLECT  = 2'd1,
    DISPATCH = 2'd2
  } state_t;

  localparam logic [SRC_WIDTH-1:0] NUM_INP_W = SRC_WIDTH'(NET_NUM_INP);
  localparam logic [SRC_WIDTH-1:0] ONE_W     = SRC_WIDTH'(1);

  state_t                   state_reg, state_next;
  logic [SRC_WIDTH-1:0]     remaining_reg, remaining_next;
  logic [NET_NUM_INP-1:0]   net_inp_reg, net_inp_next;
  logic                     err_reg, err_next;

  // One-hot decode of the incoming index; all-zero when the index is out of range.
  logic [NET_NUM_INP-1:0]   hit_vec;
  logic                     src_in_range;
  logic                     count_too_big;

  genvar gi;
  generate
    for (gi = 0; gi < NET_NUM_INP; gi++) begin : g_decode
      assign hit_vec[gi] = (src == SRC_WIDTH'(gi));
    end
  endgenerate

  assign src_in_range  = (src < NUM_INP_W);
  assign count_too_big = (src > NUM_INP_W);

  // Next-state, counter, vector and handshake outputs for the run FSM.
  // The ready/valid outputs depend only on the state, so no combinational
  // path exists from net_ready to net_valid or from src_valid to src_ready.
  always_comb begin
    state_next     = state_reg;
    remaining_next = remaining_reg;
    net_inp_next   = net_inp_reg;
    err_next       = err_reg;
    src_ready      = 1'b0;
    net_valid      = 1'b0;

    case (state_reg)
      IDLE: begin
        src_ready = 1'b1;
        if (src_valid) begin
          remaining_next = src;
          if (src == '0) begin
            // Empty run: dispatch an all-zero vector straight away.
            state_next = DISPATCH;
          end else if (count_too_big) begin
            // Oversized count is clamped so the run still terminates.
            err_next       = 1'b1;
            remaining_next = NUM_INP_W;
            state_next     = COLLECT;
          end else begin
            state_next = COLLECT;
          end
        end
      end

      COLLECT: begin
        src_ready = 1'b1;
        if (src_valid) begin
          // Bad indices are consumed and counted but leave the vector alone.
          if (src_in_range) begin
            net_inp_next = net_inp_reg | hit_vec;
          end else begin
            err_next = 1'b1;
          end
          remaining_next = remaining_reg - ONE_W;
          if (remaining_reg == ONE_W) begin
            state_next = DISPATCH;
          end
        end
      end

      DISPATCH: begin
        net_valid = 1'b1;
        if (net_ready) begin
          net_inp_next = '0;
          state_next   = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State, counter, vector and sticky error registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      remaining_reg <= '0;
      net_inp_reg   <= '0;
      err_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      remaining_reg <= remaining_next;
      net_inp_reg   <= net_inp_next;
      err_reg       <= err_next;
    end
  end

  assign net_inp = net_inp_reg;
  assign err     = err_reg;

endmodule
